// File: rtl/gpu_arb_pkg.sv
// rtl/gpu_arb_pkg.sv - shared op type, arbiter state enum and default watchdog limit
package gpu_arb_pkg;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [23:0] arg;
   } gpu_op_t;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   function automatic int default_timeout_cycles();
      return 256;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first valid index after ptr, wrapping
module rr_picker #(
   parameter  int N  = 2,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          found
);

   logic [PW-1:0] idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 1; i <= N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (!found && valid[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpu_op_arbiter.sv
// rtl/gpu_op_arbiter.sv - round-robin burst arbiter for the GPU op FIFO write port
// Optional stalled-owner watchdog and status_timeout port under GPU_OP_ARBITER_TIMEOUT_EN.
module gpu_op_arbiter
   import gpu_arb_pkg::*;
#(
   parameter int REQ_COUNT      = 2,
   parameter int TIMEOUT_CYCLES = default_timeout_cycles()
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  gpu_op_t [REQ_COUNT-1:0] req_op,
   input  logic [REQ_COUNT-1:0]    req_valid,
   input  logic [REQ_COUNT-1:0]    req_last,
   output logic [REQ_COUNT-1:0]    req_ready,
   output gpu_op_t                 op,
   output logic                    op_wr_en,
   input  logic                    op_full,
   output logic [REQ_COUNT-1:0]    grant,
   output logic                    busy
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
   ,
   output logic                    status_timeout
`endif
);

   localparam int PW = $clog2(REQ_COUNT);

   if (REQ_COUNT < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("gpu_op_arbiter: REQ_COUNT must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   arb_state_t           state_q, state_d;
   logic [REQ_COUNT-1:0] grant_q, grant_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   gpu_op_t              op_q, op_d;
   logic                 op_wr_en_q, op_wr_en_d;

   logic [REQ_COUNT-1:0] pick_onehot;
   logic                 pick_found;
   logic [PW-1:0]        owner;
   logic                 xfer;

`ifdef GPU_OP_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] stall_cnt_q, stall_cnt_d;
   logic          timeout_q, timeout_d;
`endif

   rr_picker #(.N(REQ_COUNT)) u_picker (
      .valid  (req_valid),
      .ptr    (rr_ptr_q),
      .winner (pick_onehot),
      .found  (pick_found)
   );

   always_comb begin
      owner = '0;
      for (int i = 0; i < REQ_COUNT; i++) begin
         if (grant_q[i]) owner = PW'(i);
      end
   end

   // Blocking on the previous write strobe gives op_full a cycle to reflect it.
   always_comb begin
      req_ready = '0;
      if (state_q == BURST) req_ready[owner] = ce && !op_full && !op_wr_en_q;
   end

   assign xfer = req_valid[owner] && req_ready[owner];

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      op_d       = op_q;
      op_wr_en_d = 1'b0;
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
      stall_cnt_d = stall_cnt_q;
      timeout_d   = 1'b0;
`endif
      if (ce) begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant_d = pick_onehot;
                  state_d = BURST;
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
                  stall_cnt_d = '0;
`endif
               end
            end
            BURST: begin
               if (xfer) begin
                  op_d       = req_op[owner];
                  op_wr_en_d = 1'b1;
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
                  stall_cnt_d = '0;
`endif
                  if (req_last[owner]) begin
                     rr_ptr_d = owner;
                     grant_d  = '0;
                     state_d  = IDLE;
                  end
               end
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
               else if (stall_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  rr_ptr_d    = owner;
                  grant_d     = '0;
                  state_d     = IDLE;
                  timeout_d   = 1'b1;
                  stall_cnt_d = '0;
               end else begin
                  stall_cnt_d = stall_cnt_q + CW'(1);
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= PW'(REQ_COUNT - 1);
         op_q       <= '0;
         op_wr_en_q <= 1'b0;
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         op_q       <= op_d;
         op_wr_en_q <= op_wr_en_d;
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign op       = op_q;
   assign op_wr_en = op_wr_en_q;
   assign grant    = grant_q;
   assign busy     = (state_q == BURST);
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
   assign status_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// tb/tb_gpu_op_arbiter.sv - self-checking bench for gpu_op_arbiter (vector table, directed and random phases)
module tb_gpu_op_arbiter;
   import gpu_arb_pkg::*;

   localparam int N  = 2;
   localparam int TO = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ce = 1'b0;
   logic             op_full = 1'b0;
   gpu_op_t [N-1:0]  req_op;
   logic [N-1:0]     req_valid, req_last, req_ready, grant;
   gpu_op_t          op;
   logic             op_wr_en, busy;
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
   logic             status_timeout;
`endif

   gpu_op_arbiter #(.REQ_COUNT(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ce(ce),
      .req_op(req_op), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
      .op(op), .op_wr_en(op_wr_en), .op_full(op_full),
      .grant(grant), .busy(busy)
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
      , .status_timeout(status_timeout)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { gpu_op_t op; bit last; } item_t;
   typedef struct {
      logic ce; logic [1:0] v; logic [1:0] l; logic full; gpu_op_t op0; gpu_op_t op1;
      logic [1:0] eg; logic eb; logic [1:0] er; logic ew; gpu_op_t eop;
   } vec_t;

   int      checks = 0, failures = 0, cyc = 0;
   item_t   src_q [N][$];
   gpu_op_t wr_log[$], exp_log[$];
   int      grant_log[$];
   int      m_owner = -1, m_last = N - 1, m_stall = 0, to_seen = 0;
   bit      m_wr_pend = 0, m_to_pend = 0;
   gpu_op_t m_wr_op = '0;
   int      drop_pct = 0, full_pct = 0, ce_off_pct = 0;
   bit      full_force = 0;
   bit      mute [N];
   int      start_cyc [N];
   vec_t    vec [13];
   int      n0, total;
   int      fexp [4];

   localparam gpu_op_t OZ = '0;
   localparam gpu_op_t OA = gpu_op_t'(32'hA000_0001);
   localparam gpu_op_t OB = gpu_op_t'(32'hB000_0002);
   localparam gpu_op_t OC = gpu_op_t'(32'hC000_0003);
   localparam gpu_op_t OD = gpu_op_t'(32'hD000_0004);

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   task automatic add_burst(int r, int len, logic [31:0] base);
      item_t it;
      for (int k = 0; k < len; k++) begin
         it.op   = gpu_op_t'(base + 32'(k));
         it.last = (k == len - 1);
         src_q[r].push_back(it);
         exp_log.push_back(it.op);
      end
   endtask

   function automatic bit drained();
      bit d = (m_owner < 0) && !m_wr_pend;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) d = 0;
      return d;
   endfunction

   // One clock: drive producers from their queues, check outputs against the model, advance it.
   task automatic tick();
      logic [N-1:0] e_grant, e_ready;
      bit xfer, lastf;
      int best, win, d;
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() != 0 && !mute[i] && cyc >= start_cyc[i] &&
             $urandom_range(99) >= drop_pct) begin
            req_valid[i] = 1'b1; req_op[i] = src_q[i][0].op; req_last[i] = src_q[i][0].last;
         end else begin
            req_valid[i] = 1'b0; req_op[i] = gpu_op_t'($urandom); req_last[i] = 1'($urandom);
         end
      end
      ce      = ($urandom_range(99) >= ce_off_pct);
      op_full = full_force || ($urandom_range(99) < full_pct);
      @(negedge clk);
      e_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      e_ready = (m_owner >= 0 && ce && !op_full && !m_wr_pend) ? e_grant : '0;
      chk("grant", 64'(grant), 64'(e_grant));
      chk("busy", 64'(busy), 64'(m_owner >= 0));
      chk("ready", 64'(req_ready), 64'(e_ready));
      chk("wr_en", 64'(op_wr_en), 64'(m_wr_pend));
      if (m_wr_pend) chk("op", 64'(op), 64'(m_wr_op));
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
      chk("timeout", 64'(status_timeout), 64'(m_to_pend));
      if (status_timeout) to_seen++;
`endif
      if (op_wr_en) wr_log.push_back(op);
      xfer      = |(req_valid & e_ready);
      lastf     = |(req_last & e_grant);
      m_wr_pend = xfer;
      m_to_pend = 0;
      for (int i = 0; i < N; i++) if (xfer && i == m_owner) m_wr_op = req_op[i];
      if (ce) begin
         if (m_owner < 0) begin
            best = N; win = 0;
            for (int i = 0; i < N; i++) begin
               d = (i - m_last - 1 + 2 * N) % N;
               if (req_valid[i] && d < best) begin best = d; win = i; end
            end
            if (best < N) begin m_owner = win; grant_log.push_back(win); m_stall = 0; end
         end else if (xfer) begin
            void'(src_q[m_owner].pop_front());
            m_stall = 0;
            if (lastf) begin m_last = m_owner; m_owner = -1; end
         end else begin
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
            m_stall++;
            if (m_stall == TO) begin m_last = m_owner; m_owner = -1; m_to_pend = 1; m_stall = 0; end
`endif
         end
      end
      cyc++;
      @(posedge clk); #1;
   endtask

   task automatic run_until(string name, int max);
      int n = 0;
      while (!drained() && n < max) begin tick(); n++; end
      chk(name, 64'(drained()), 64'(1));
   endtask

   task automatic run_wr(int k, int max);
      int n = 0;
      while (wr_log.size() < k && n < max) begin tick(); n++; end
      chk("wr_wait", 64'(wr_log.size() >= k), 64'(1));
   endtask

   task automatic check_log(string name);
      chk({name, "_len"}, 64'(wr_log.size()), 64'(exp_log.size()));
      for (int k = 0; k < wr_log.size() && k < exp_log.size(); k++)
         chk(name, 64'(wr_log[k]), 64'(exp_log[k]));
   endtask

   task automatic clear_logs();
      wr_log.delete(); exp_log.delete(); grant_log.delete();
   endtask

   initial begin
      req_valid = '0; req_last = '0; req_op = '0;
      for (int i = 0; i < N; i++) begin mute[i] = 0; start_cyc[i] = 0; end
      vec[0]  = '{1'b1, 2'b01, 2'b00, 1'b0, OA, OZ, 2'b00, 1'b0, 2'b00, 1'b0, OZ};
      vec[1]  = '{1'b1, 2'b01, 2'b00, 1'b0, OA, OZ, 2'b01, 1'b1, 2'b01, 1'b0, OZ};
      vec[2]  = '{1'b1, 2'b11, 2'b00, 1'b0, OB, OD, 2'b01, 1'b1, 2'b00, 1'b1, OA};
      vec[3]  = '{1'b1, 2'b11, 2'b00, 1'b0, OB, OD, 2'b01, 1'b1, 2'b01, 1'b0, OA};
      vec[4]  = '{1'b1, 2'b11, 2'b01, 1'b0, OC, OD, 2'b01, 1'b1, 2'b00, 1'b1, OB};
      vec[5]  = '{1'b1, 2'b11, 2'b01, 1'b0, OC, OD, 2'b01, 1'b1, 2'b01, 1'b0, OB};
      vec[6]  = '{1'b1, 2'b00, 2'b00, 1'b0, OZ, OZ, 2'b00, 1'b0, 2'b00, 1'b1, OC};
      vec[7]  = '{1'b1, 2'b11, 2'b11, 1'b0, OA, OD, 2'b00, 1'b0, 2'b00, 1'b0, OC};
      vec[8]  = '{1'b0, 2'b10, 2'b10, 1'b0, OZ, OD, 2'b10, 1'b1, 2'b00, 1'b0, OC};
      vec[9]  = '{1'b1, 2'b10, 2'b10, 1'b1, OZ, OD, 2'b10, 1'b1, 2'b00, 1'b0, OC};
      vec[10] = '{1'b1, 2'b10, 2'b10, 1'b0, OZ, OD, 2'b10, 1'b1, 2'b10, 1'b0, OC};
      vec[11] = '{1'b0, 2'b00, 2'b00, 1'b0, OZ, OZ, 2'b00, 1'b0, 2'b00, 1'b1, OD};
      vec[12] = '{1'b1, 2'b00, 2'b00, 1'b0, OZ, OZ, 2'b00, 1'b0, 2'b00, 1'b0, OD};

      repeat (2) @(posedge clk);
      #2;
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_wr", 64'({op_wr_en, op}), 64'(0));
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // single-requester burst, ignored second requester, ce freeze, full stall
      for (int r = 0; r < 13; r++) begin
         ce = vec[r].ce; req_valid = vec[r].v; req_last = vec[r].l; op_full = vec[r].full;
         req_op[0] = vec[r].op0; req_op[1] = vec[r].op1;
         @(negedge clk);
         chk("tbl_grant_busy", 64'({grant, busy}), 64'({vec[r].eg, vec[r].eb}));
         chk("tbl_ready", 64'(req_ready), 64'(vec[r].er));
         chk("tbl_wr_op", 64'({op_wr_en, op}), 64'({vec[r].ew, vec[r].eop}));
         cyc++;
         @(posedge clk); #1;
      end
      m_owner = -1; m_last = 1; m_wr_pend = 0; m_stall = 0;

      // FIFO full held for 10 cycles mid-burst
      clear_logs();
      add_burst(0, 3, 32'h5000_0010);
      run_wr(1, 20);
      n0 = wr_log.size();
      full_force = 1;
      repeat (10) tick();
      chk("full_no_wr", 64'(wr_log.size()), 64'(n0));
      full_force = 0;
      run_until("full_drain", 60);
      check_log("full_log");

      // requester 1 shows up mid-way through requester 0's burst
      clear_logs();
      add_burst(0, 4, 32'h6000_0020);
      add_burst(1, 1, 32'h7000_0030);
      start_cyc[1] = cyc + 5;
      run_until("nointl_drain", 100);
      check_log("nointl_log");
      start_cyc[1] = 0;

      // async reset between edges mid-burst
      clear_logs();
      add_burst(0, 4, 32'h8000_0040);
      run_wr(1, 20);
      #1 rst = 1'b1;
      #1;
      chk("arst_grant_busy", 64'({grant, busy}), 64'(0));
      chk("arst_ready", 64'(req_ready), 64'(0));
      chk("arst_wr_op", 64'({op_wr_en, op}), 64'(0));
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
      chk("arst_timeout", 64'(status_timeout), 64'(0));
`endif
      #1 rst = 1'b0;
      m_owner = -1; m_last = N - 1; m_wr_pend = 0; m_stall = 0; m_to_pend = 0;
      for (int i = 0; i < N; i++) src_q[i].delete();

      // fairness with single-op bursts, requester 0 first after reset
      clear_logs();
      add_burst(0, 1, 32'h9000_0000);
      add_burst(1, 1, 32'h9100_0000);
      add_burst(0, 1, 32'h9000_0001);
      add_burst(1, 1, 32'h9100_0001);
      run_until("fair_drain", 60);
      check_log("fair_log");
      fexp = '{0, 1, 0, 1};
      chk("fair_len", 64'(grant_log.size()), 64'(4));
      for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("fair_order", 64'(grant_log[k]), 64'(fexp[k]));

`ifdef GPU_OP_ARBITER_TIMEOUT_EN
      // owner stalls after one op; watchdog hands the port to requester 1
      clear_logs();
      to_seen = 0;
      add_burst(0, 2, 32'hAA00_0000);
      add_burst(1, 1, 32'hBB00_0000);
      run_wr(1, 20);
      mute[0] = 1;
      for (int n = 0; n < 30 && to_seen == 0; n++) tick();
      chk("wd_pulse", 64'(to_seen), 64'(1));
      mute[0] = 0;
      run_until("wd_drain", 60);
      fexp = '{0, 1, 0, 0};
      chk("wd_grants_len", 64'(grant_log.size()), 64'(3));
      for (int k = 0; k < 3 && k < grant_log.size(); k++) chk("wd_grants", 64'(grant_log[k]), 64'(fexp[k]));
      chk("wd_order", 64'(wr_log.size() == 3 ? wr_log[1] : OZ), 64'(gpu_op_t'(32'hBB00_0000)));
`endif

      // randomized bursts, drops, FIFO-full and ce gaps
      clear_logs();
      drop_pct = 25; full_pct = 25; ce_off_pct = 10;
      total = 0;
      for (int r = 0; r < N; r++) begin
         for (int b = 0; b < 12; b++) begin
            n0 = 1 + $urandom_range(3);
            add_burst(r, n0, $urandom);
            total += n0;
         end
      end
      run_until("rand_drain", 5000);
      chk("rand_count", 64'(wr_log.size()), 64'(total));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
